// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared types for the I2S receive-path frame controller
package i2s_pkg;

   localparam int SAMPLE_W = 24;

   typedef logic [SAMPLE_W-1:0] sample_t;

   typedef struct packed {
      sample_t left;
      sample_t right;
   } stereo_t;

   typedef enum logic {
      WAIT_L = 1'b0,
      WAIT_R = 1'b1
   } frame_state_t;

endpackage

// File: rtl/i2s_lrclk_gen.sv
// rtl/i2s_lrclk_gen.sv - word-select generator, toggles lrclk every HALF_FRAME sclk cycles
module i2s_lrclk_gen #(
   parameter int HALF_FRAME = 32
) (
   input  logic sclk,
   input  logic rst,
   input  logic en,
   output logic lrclk
);

   localparam logic [7:0] DIV_LAST = 8'(HALF_FRAME - 1);

   logic [7:0] div;

   // Disabling parks the divider at 0 so a re-enable gives a full half period.
   always_ff @(posedge sclk) begin
      if (rst) begin
         div   <= 8'd0;
         lrclk <= 1'b0;
      end else if (!en) begin
         div   <= 8'd0;
      end else if (div == DIV_LAST) begin
         div   <= 8'd0;
         lrclk <= ~lrclk;
      end else begin
         div   <= div + 8'd1;
      end
   end

endmodule

// File: rtl/i2s_frame_ctrl.sv
// rtl/i2s_frame_ctrl.sv - tags receiver samples L/R, pairs them into stereo frames, valid/ready output
// Optional frame/overflow counters when I2S_FRAME_CTRL_STATS_EN is defined.
module i2s_frame_ctrl #(
   parameter int HALF_FRAME = 32,
   parameter int SAMPLE_W   = 24
) (
   input  logic                sclk,
   input  logic                rst,
   input  logic                en,
   output logic                lrclk,
   input  logic [SAMPLE_W-1:0] rx_data,
   input  logic                rx_dvalid,
   output logic [SAMPLE_W-1:0] out_left,
   output logic [SAMPLE_W-1:0] out_right,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overflow,
`ifdef I2S_FRAME_CTRL_STATS_EN
   output logic [15:0]         frame_cnt,
   output logic [7:0]          ovf_cnt,
`endif
   output logic                order_err
);

   import i2s_pkg::*;

   frame_state_t        state;
   frame_state_t        state_nxt;
   logic                dv_q;
   logic                rise;
   logic                load_left;
   logic                complete;
   logic                order_err_nxt;
   logic                take;
   logic                load_slot;
   logic                drop;
   logic [SAMPLE_W-1:0] hold_left;

   i2s_lrclk_gen #(
      .HALF_FRAME (HALF_FRAME)
   ) u_lrclk_gen (
      .sclk  (sclk),
      .rst   (rst),
      .en    (en),
      .lrclk (lrclk)
   );

   assign rise = rx_dvalid & ~dv_q;

   always_ff @(posedge sclk) begin
      if (rst) begin
         state <= WAIT_L;
         dv_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         dv_q  <= rx_dvalid;
      end
   end

   // The channel tag is the lrclk level at the dvalid rising edge.
   always_comb begin
      state_nxt     = state;
      load_left     = 1'b0;
      complete      = 1'b0;
      order_err_nxt = 1'b0;
      if (rise) begin
         case (state)
            WAIT_L: begin
               if (!lrclk) begin
                  load_left = 1'b1;
                  state_nxt = WAIT_R;
               end else begin
                  order_err_nxt = 1'b1;
               end
            end
            WAIT_R: begin
               if (lrclk) begin
                  complete  = 1'b1;
                  state_nxt = WAIT_L;
               end else begin
                  order_err_nxt = 1'b1;
                  load_left     = 1'b1;
               end
            end
            default: state_nxt = WAIT_L;
         endcase
      end
   end

   assign take      = out_valid & out_ready;
   assign load_slot = complete & (~out_valid | take);
   assign drop      = complete & ~load_slot;

   always_ff @(posedge sclk) begin
      if (rst) begin
         hold_left <= '0;
         out_left  <= '0;
         out_right <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
         order_err <= 1'b0;
      end else begin
         overflow  <= drop;
         order_err <= order_err_nxt;
         if (load_left) begin
            hold_left <= rx_data;
         end
         if (load_slot) begin
            out_left  <= hold_left;
            out_right <= rx_data;
            out_valid <= 1'b1;
         end else if (take) begin
            out_valid <= 1'b0;
         end
      end
   end

`ifdef I2S_FRAME_CTRL_STATS_EN
   always_ff @(posedge sclk) begin
      if (rst) begin
         frame_cnt <= 16'd0;
         ovf_cnt   <= 8'd0;
      end else begin
         if (load_slot) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
         if (drop && ovf_cnt != 8'hFF) begin
            ovf_cnt <= ovf_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_i2s_frame_ctrl.sv
// tb/tb_i2s_frame_ctrl.sv - directed and randomized bench for i2s_frame_ctrl with a frame-level reference model
module tb_i2s_frame_ctrl;

   localparam int HF = 32;
   localparam int SW = 24;

   logic          sclk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          lrclk;
   logic [SW-1:0] rx_data = '0;
   logic          rx_dvalid = 1'b0;
   logic [SW-1:0] out_left;
   logic [SW-1:0] out_right;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          overflow;
   logic          order_err;
`ifdef I2S_FRAME_CTRL_STATS_EN
   logic [15:0]   frame_cnt;
   logic [7:0]    ovf_cnt;
`endif

   i2s_frame_ctrl #(.HALF_FRAME(HF), .SAMPLE_W(SW)) dut (
      .sclk      (sclk),
      .rst       (rst),
      .en        (en),
      .lrclk     (lrclk),
      .rx_data   (rx_data),
      .rx_dvalid (rx_dvalid),
      .out_left  (out_left),
      .out_right (out_right),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .overflow  (overflow),
`ifdef I2S_FRAME_CTRL_STATS_EN
      .frame_cnt (frame_cnt),
      .ovf_cnt   (ovf_cnt),
`endif
      .order_err (order_err)
   );

   always #5 sclk = ~sclk;

   int n_cmp = 0;
   int n_bad = 0;

   // observations
   logic [2*SW-1:0] got_q[$];
   int n_oerr = 0;
   int n_ovf  = 0;

   // reference model state
   logic [2*SW-1:0] exp_q[$];
   int          e_oerr = 0;
   int          e_ovf  = 0;
   bit          m_has_left = 0;
   logic [SW-1:0] m_left = '0;
   bit          m_slot_v = 0;
   logic [2*SW-1:0] m_slot = '0;
   bit          ready_mode = 0;
   int          m_fcnt = 0;
   int          m_ocnt = 0;

   always @(negedge sclk) begin
      #2;
      if (order_err) n_oerr++;
      if (overflow) n_ovf++;
      if (out_valid && out_ready) got_q.push_back({out_left, out_right});
   end

   task automatic step();
      @(negedge sclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic timeout(input string tag);
      n_cmp++;
      n_bad++;
      $error("FAIL %s: timeout waiting for lrclk", tag);
   endtask

   task automatic model_sample(input logic chan, input logic [SW-1:0] d, input bit rdy);
      if (!m_has_left) begin
         if (chan == 1'b0) begin
            m_left = d;
            m_has_left = 1;
         end else begin
            e_oerr++;
         end
      end else if (chan == 1'b1) begin
         m_has_left = 0;
         if (!m_slot_v || rdy) begin
            if (m_slot_v) exp_q.push_back(m_slot);
            m_slot = {m_left, d};
            m_slot_v = 1;
            m_fcnt++;
         end else begin
            e_ovf++;
            if (m_ocnt < 255) m_ocnt++;
         end
      end else begin
         e_oerr++;
         m_left = d;
      end
      if (ready_mode && m_slot_v) begin
         exp_q.push_back(m_slot);
         m_slot_v = 0;
      end
   endtask

   task automatic set_ready(input bit r);
      out_ready = r;
      ready_mode = r;
      if (r && m_slot_v) begin
         exp_q.push_back(m_slot);
         m_slot_v = 0;
      end
   endtask

   // Receiver stand-in: dvalid ~25 cycles after the start of the requested half.
   task automatic send(input logic chan, input logic [SW-1:0] d, input bit pulse_ready);
      int n = 0;
      while (lrclk == chan && n < 200) begin step(); n++; end
      while (lrclk != chan && n < 200) begin step(); n++; end
      if (n >= 200) timeout("send_wait");
      repeat (25) step();
      rx_data = d;
      rx_dvalid = 1'b1;
      if (pulse_ready) out_ready = 1'b1;
      step();
      if (pulse_ready) out_ready = 1'b0;
      step();
      step();
      rx_dvalid = 1'b0;
      rx_data = SW'($urandom);
      step();
      model_sample(chan, d, pulse_ready || ready_mode);
   endtask

   task automatic check_all(input string tag);
      int n;
      repeat (3) step();
      chk({tag, ".frames"}, 64'(got_q.size()), 64'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, ".frame"}, 64'(got_q[i]), 64'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
      chk({tag, ".order_err_cnt"}, 64'(n_oerr), 64'(e_oerr));
      chk({tag, ".overflow_cnt"}, 64'(n_ovf), 64'(e_ovf));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_slot_v));
      if (m_slot_v) chk({tag, ".held"}, 64'({out_left, out_right}), 64'(m_slot));
`ifdef I2S_FRAME_CTRL_STATS_EN
      chk({tag, ".frame_cnt"}, 64'(frame_cnt), 64'(m_fcnt & 16'hFFFF));
      chk({tag, ".ovf_cnt"}, 64'(ovf_cnt), 64'(m_ocnt));
`endif
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      step();
      chk({tag, ".lrclk"}, 64'(lrclk), 64'd0);
      chk({tag, ".out_valid"}, 64'(out_valid), 64'd0);
      chk({tag, ".out_data"}, 64'({out_left, out_right}), 64'd0);
      chk({tag, ".pulses"}, 64'({overflow, order_err}), 64'd0);
`ifdef I2S_FRAME_CTRL_STATS_EN
      chk({tag, ".stats"}, 64'({frame_cnt, ovf_cnt}), 64'd0);
`endif
      rst = 1'b0;
      m_has_left = 0;
      m_slot_v = 0;
      m_fcnt = 0;
      m_ocnt = 0;
   endtask

   initial begin
      int n;
      logic [SW-1:0] a, b, c, d;

      repeat (2) step();
      do_reset("reset");

      // lrclk timing from the first enabled cycle
      en = 1'b1;
      n = 0;
      do begin step(); n++; end while (!lrclk && n < 100);
      chk("first_rise", 64'(n), 64'(HF));
      en = 1'b0;
      repeat (40) step();
      chk("en_hold", 64'(lrclk), 64'd1);
      en = 1'b1;
      n = 0;
      do begin step(); n++; end while (lrclk && n < 100);
      chk("reenable_toggle", 64'(n), 64'(HF));
      n = 0;
      do begin step(); n++; end while (!lrclk && n < 100);
      chk("half_period", 64'(n), 64'(HF));
      check_all("idle");

      // basic frame
      set_ready(1);
      send(1'b0, 24'h123456, 0);
      send(1'b1, 24'hABCDEF, 0);
      check_all("basic");

      // right first after reset, then a normal pair
      do_reset("reset2");
      send(1'b1, 24'h0BAD01, 0);
      check_all("right_first");
      a = SW'($urandom); b = SW'($urandom);
      send(1'b0, a, 0);
      send(1'b1, b, 0);
      check_all("after_err");

      // back-pressure across two frames
      set_ready(0);
      a = SW'($urandom); b = SW'($urandom); c = SW'($urandom); d = SW'($urandom);
      send(1'b0, a, 0);
      send(1'b1, b, 0);
      check_all("held1");
      send(1'b0, c, 0);
      send(1'b1, d, 0);
      check_all("overflow");
      set_ready(1);
      check_all("release");

      // consume and load in the same cycle
      set_ready(0);
      a = SW'($urandom); b = SW'($urandom); c = SW'($urandom); d = SW'($urandom);
      send(1'b0, a, 0);
      send(1'b1, b, 0);
      send(1'b0, c, 0);
      send(1'b1, d, 1);
      check_all("simultaneous");
      set_ready(1);
      check_all("release2");

      // reset between L and R
      send(1'b0, SW'($urandom), 0);
      do_reset("reset_mid");
      send(1'b1, SW'($urandom), 0);
      check_all("post_reset_r");

      // random channel order and data
      for (int i = 0; i < 16; i++) begin
         send(1'($urandom_range(0, 1)), SW'($urandom), 0);
      end
      check_all("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_frame_ctrl.md
# i2s_frame_ctrl

Sequencer and frame assembler for the I2S receive path. It generates `lrclk` from `sclk` to drive the 24-bit I2S receiver and the ADC, and watches the receiver's `data`/`dvalid` outputs. It tags each sample as left or right, pairs the samples into stereo frames, and hands the frames to the effects chain over a valid/ready handshake, flagging overruns and channel-order errors.

## Interface
Parameters:
- `HALF_FRAME`, 32: sclk cycles per lrclk half-period; legal range 28..255.
- `SAMPLE_W`, 24: sample width; must match the receiver.

Ports:
- `sclk`  in  1  bit clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  lrclk generation enable.
- `lrclk`  out  1  word select to receiver and ADC; 0 = left half, 1 = right half.
- `rx_data`  in  SAMPLE_W  sample from receiver.
- `rx_dvalid`  in  1  receiver valid level.
- `out_left`  out  SAMPLE_W  left sample of the held frame.
- `out_right`  out  SAMPLE_W  right sample of the held frame.
- `out_valid`  out  1  frame available.
- `out_ready`  in  1  downstream accepts.
- `overflow`  out  1  1-cycle pulse: completed frame dropped.
- `order_err`  out  1  1-cycle pulse: sample arrived in the wrong channel order.

## Operation
- lrclk generator: 8-bit counter `div`.
  - With `en`=1, `div` increments each cycle.
  - At `div`==HALF_FRAME-1, `div` goes to 0 and `lrclk` toggles.
  - With `en`=0, `div` is forced to 0 and `lrclk` holds its value.
- Sample detect: `dv_q` registers `rx_dvalid`. `rise = rx_dvalid & ~dv_q`. Channel tag = current `lrclk` at `rise`.
- FSM states and transitions:
  - WAIT_L, on rise:
    - tag 0: latch `rx_data` into the left holding register, go to WAIT_R.
    - tag 1: pulse `order_err`, discard the sample, stay in WAIT_L.
  - WAIT_R, on rise:
    - tag 1: complete the pair and go to WAIT_L.
    - tag 0: pulse `order_err`, overwrite the left holding register, stay in WAIT_R.
- Pair completion:
  - If the output slot is empty, or is being consumed this cycle (`out_valid & out_ready`): load `out_left` from the holding register and `out_right` from `rx_data`, and set `out_valid`.
  - Otherwise: keep the old frame, discard the new one, pulse `overflow`.
- Handshake: `out_valid` stays high until `out_valid & out_ready`. `out_left`/`out_right` stay stable while `out_valid`=1. A transfer with no simultaneous load clears `out_valid`.
- `en` deassert mid-frame: the FSM state is kept; samples already in flight complete normally.

## Timing
- Reset values:
  - `lrclk`=0, `div`=0, `dv_q`=0.
  - FSM in WAIT_L, holding register 0.
  - `out_left`=`out_right`=0, `out_valid`=0, `overflow`=0, `order_err`=0.
- First `lrclk` toggle occurs HALF_FRAME cycles after the first cycle with `rst`=0 and `en`=1. `lrclk` period = 2·HALF_FRAME cycles.
- `rise` is seen in the cycle `rx_dvalid` is first sampled high.
  - Captures and the `out_valid`/`overflow`/`order_err` updates are registered: visible on the next edge (latency 1).
- HALF_FRAME ≥ 28 guarantees the receiver's dvalid (about 25 cycles after the lrclk edge) falls inside the same half. The tag is therefore correct.
- Reset mid-frame: all state returns to reset values in the next cycle; a partial left sample is lost.

## Configuration
- `I2S_FRAME_CTRL_STATS_EN` defined:
  - Adds output `frame_cnt` [15:0]: wrapping count of frames accepted into the output slot.
  - Adds output `ovf_cnt` [7:0]: count of `overflow` pulses, saturating at 255.
  - Both reset to 0.
- Not defined: neither port nor its counter exists; all other behaviour is identical.

## Structure
- Package `i2s_pkg`:
  - `SAMPLE_W` constant.
  - `typedef logic [SAMPLE_W-1:0] sample_t`.
  - `typedef struct packed {sample_t left; sample_t right;} stereo_t`.
  - FSM enum `frame_state_t` {WAIT_L, WAIT_R}.
- Sub-module `i2s_lrclk_gen`: holds `div` and the `lrclk` toggle; ports sclk, rst, en, lrclk.
- FSM, holding register, output slot and optional stats stay in the top.

## Test plan
- Reset, then en=1 with HALF_FRAME=32: first `lrclk` rise 32 cycles after reset release, then toggles every 32 cycles; outputs stay at reset values throughout.
- Receiver model sends L=0x123456, R=0xABCDEF with `out_ready`=1: one cycle with `out_valid`=1 and `out_left`=0x123456, `out_right`=0xABCDEF; no error pulses.
- `out_ready`=0 across two complete frames: first frame held stable; one `overflow` pulse when the second pair completes; with STATS_EN, `ovf_cnt`=1 and `frame_cnt`=1.
- Right sample first after reset (rise while `lrclk`=1): `order_err` pulses once, no frame is produced; the next L/R pair is delivered normally.
- `out_ready` asserted in the same cycle a new pair completes: old frame transfers, new frame loads, `out_valid` stays 1, no `overflow`.
- `rst` asserted between L and R capture: next cycle all outputs are at reset values; the following R-only sample raises `order_err`.
